// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full-adder cell shared by every serial step.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              fa_s, fa_co;

  full_adder u_fa (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch;
    // blocking assignments are correct here because this block is combinational.
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B once here and seed the carry with 1.
          state_d = SHIFT;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      SHIFT: begin
        sum_d[cnt_q] = fa_s;
        carry_d      = fa_co;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q is the carry into the MSB, fa_co the carry out of it.
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: operand registers are reset too, so no X ever reaches the adder cell.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder at WIDTH = 8, 4 and 1.
module tb_serial_adder;

  logic clk;
  logic reset;

  logic       start8, sub8;
  logic [7:0] a8, b8, sum8;
  logic       busy8, done8, cout8, ovf8;

  logic       start4, sub4;
  logic [3:0] a4, b4, sum4;
  logic       busy4, done4, cout4, ovf4;

  logic       start1, sub1;
  logic [0:0] a1, b1, sum1;
  logic       busy1, done1, cout1, ovf1;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain integer arithmetic and the sign rule.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint mask, bb, full, r;
    logic   sa, sb, sr, c, o;
    mask = (longint'(1) << w) - 1;
    bb   = s ? (~longint'(b) & mask) : longint'(b);
    full = longint'(a) + bb + longint'(s);
    r    = full & mask;
    c    = full[w];
    sa   = a[w-1];
    sb   = b[w-1];
    sr   = r[w-1];
    o    = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {o, c, r[31:0]};
  endfunction

  task automatic wait_done8(output int n);
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    while (done4 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    while (done1 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] esum, input logic ecout, input logic eovf);
    int n;
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check({tag, "_busy_shift"}, busy8, 1'b1);
    check({tag, "_done_shift"}, done8, 1'b0);
    wait_done8(n);
    check({tag, "_latency"}, n, 8);
    check({tag, "_sum"}, sum8, esum);
    check({tag, "_cout"}, cout8, ecout);
    check({tag, "_ovf"}, ovf8, eovf);
    tick();
    check({tag, "_done_pulse"}, done8, 1'b0);
    check({tag, "_busy_idle"}, busy8, 1'b0);
    check({tag, "_sum_hold"}, sum8, esum);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int n;
    logic [33:0] m;
    m = model(4, 32'(a), 32'(b), s);
    a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    wait_done4(n);
    check($sformatf("w4_lat_%h_%h_%b", a, b, s), n, 4);
    check($sformatf("w4_sum_%h_%h_%b", a, b, s), sum4, m[3:0]);
    check($sformatf("w4_cout_%h_%h_%b", a, b, s), cout4, m[32]);
    check($sformatf("w4_ovf_%h_%h_%b", a, b, s), ovf4, m[33]);
    tick();
  endtask

  task automatic run1(input logic a, input logic b, input logic s);
    int n;
    logic [33:0] m;
    m = model(1, 32'(a), 32'(b), s);
    a1 = a; b1 = b; sub1 = s; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done1(n);
    check($sformatf("w1_lat_%b_%b_%b", a, b, s), n, 1);
    check($sformatf("w1_sum_%b_%b_%b", a, b, s), sum1, m[0]);
    check($sformatf("w1_cout_%b_%b_%b", a, b, s), cout1, m[32]);
    check($sformatf("w1_ovf_%b_%b_%b", a, b, s), ovf1, m[33]);
    tick();
  endtask

  initial begin
    int n;
    int seen;

    reset = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_busy", busy8, 1'b0);
      check("rst_done", done8, 1'b0);
      check("rst_sum", sum8, 8'h00);
      check("rst_cout", cout8, 1'b0);
      check("rst_ovf", ovf8, 1'b0);
    end

    // Directed WIDTH=8 vectors.
    run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run8("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start pulses during SHIFT and DONE are ignored.
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8(n);
    check("hs_latency", n, 4);
    check("hs_sum", sum8, 8'h46);
    check("hs_cout", cout8, 1'b0);
    check("hs_ovf", ovf8, 1'b0);
    a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("hs_done_ign_busy", busy8, 1'b0);
    check("hs_done_ign_done", done8, 1'b0);
    tick();
    check("hs_still_idle", busy8, 1'b0);
    check("hs_sum_hold", sum8, 8'h46);

    // Start held high: back-to-back ops every WIDTH+2 cycles; busy-time operand changes apply only to the next op.
    a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'h20; b8 = 8'h30; sub8 = 1'b1;
    wait_done8(n);
    check("b2b_lat1", n, 8);
    check("b2b_sum1", sum8, 8'h30);
    check("b2b_cout1", cout8, 1'b0);
    check("b2b_ovf1", ovf8, 1'b0);
    n = 0;
    do begin
      tick();
      n++;
    end while (done8 !== 1'b1 && n < 40);
    check("b2b_period", n, 10);
    check("b2b_sum2", sum8, 8'hF0);
    check("b2b_cout2", cout8, 1'b0);
    check("b2b_ovf2", ovf8, 1'b0);
    start8 = 1'b0;
    tick();
    tick();
    check("b2b_idle", busy8, 1'b0);

    // Reset during the 4th SHIFT cycle discards the operation.
    a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", busy8, 1'b0);
    check("mid_rst_done", done8, 1'b0);
    check("mid_rst_sum", sum8, 8'h00);
    check("mid_rst_cout", cout8, 1'b0);
    check("mid_rst_ovf", ovf8, 1'b0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 === 1'b1 || busy8 === 1'b1) seen = 1;
    end
    check("mid_rst_quiet", seen, 0);
    run8("after_rst", 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0);

    // Exhaustive WIDTH=4 and WIDTH=1 against the reference model.
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          run4(4'(x), 4'(y), 1'(s));
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 2; x++)
        for (int y = 0; y < 2; y++)
          run1(1'(x), 1'(y), 1'(s));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
